// File: rtl/ipu_window_sequencer.sv
// ipu_window_sequencer: walks a frame in raster order, builds a zero-padded 5x5 window per pixel, runs one coprocessor convolution per window and writes the saturated result
//   clk, reset_n                  : clock, asynchronous active-low reset
//   start, mode, kernel_b         : frame start, filter select, 25x8-bit kernel
//   busy, done                    : status, end-of-frame pulse
//   src_addr/src_rdata            : source RAM read port (1-cycle latency)
//   dst_addr/dst_wdata/dst_we     : destination RAM write port
//   ipu_request, window_a/b, cop_*: coprocessor external-matrix interface
module ipu_window_sequencer #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [199:0]      kernel_b,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rdata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wdata,
  output logic              dst_we,
  output logic              ipu_request,
  output logic [199:0]      window_a,
  output logic [199:0]      window_b,
  output logic [31:0]       cop_instruction,
  output logic              cop_activate,
  input  logic              cop_wait,
  input  logic              cop_done,
  input  logic [31:0]       cop_result
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE} state_t;
  localparam logic signed [ADDR_W:0] TWO = 2;
  localparam logic signed [ADDR_W:0] W_S = (ADDR_W+1)'(IMG_W);
  localparam logic signed [ADDR_W:0] H_S = (ADDR_W+1)'(IMG_H);
  state_t              r_state;
  logic [ADDR_W-1:0]   r_x, r_y;
  logic [4:0]          r_k;
  logic [2:0]          r_r, r_c;
  logic                r_inb, r_armed;
  logic signed [ADDR_W:0] w_row, w_col;
  logic                w_inb, w_last;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_sat;
  logic [1:0]          w_mode;
  assign w_row  = $signed({1'b0, r_y}) + $signed({{(ADDR_W-2){1'b0}}, r_r}) - TWO;
  assign w_col  = $signed({1'b0, r_x}) + $signed({{(ADDR_W-2){1'b0}}, r_c}) - TWO;
  assign w_inb  = !w_row[ADDR_W] && !w_col[ADDR_W] && (w_row < H_S) && (w_col < W_S);
  assign w_addr = w_row[ADDR_W-1:0] * ADDR_W'(IMG_W) + w_col[ADDR_W-1:0];
  assign w_last = (r_x == ADDR_W'(IMG_W-1)) && (r_y == ADDR_W'(IMG_H-1));
  assign w_sat  = cop_result[23] ? 8'd0 : (|cop_result[22:8] ? 8'hFF : cop_result[7:0]);
  assign w_mode = (mode == 2'b00) ? 2'b01 : mode;
  assign src_addr    = (r_state == S_FETCH && r_k < 5'd25 && w_inb) ? w_addr : '0;
  assign busy        = r_state != S_IDLE;
  assign ipu_request = r_state == S_ISSUE || r_state == S_WAIT;
  assign window_b    = busy ? kernel_b : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_k             <= '0;
      r_r             <= '0;
      r_c             <= '0;
      r_inb           <= 1'b0;
      r_armed         <= 1'b0;
      done            <= 1'b0;
      dst_addr        <= '0;
      dst_wdata       <= '0;
      dst_we          <= 1'b0;
      window_a        <= '0;
      cop_instruction <= '0;
      cop_activate    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_x             <= '0;
            r_y             <= '0;
            r_k             <= '0;
            r_r             <= '0;
            r_c             <= '0;
            cop_instruction <= {28'd0, 2'b01, w_mode};
            r_state         <= S_FETCH;
          end
        end
        S_FETCH: begin
          // element k arrives one cycle after its address; shifting 25 times leaves element 0 in the low byte
          r_inb <= w_inb;
          if (r_k != 5'd0) window_a <= {r_inb ? src_rdata : 8'd0, window_a[199:8]};
          if (r_k == 5'd25) begin
            cop_activate <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_k <= r_k + 5'd1;
            r_c <= (r_c == 3'd4) ? 3'd0 : r_c + 3'd1;
            r_r <= (r_c == 3'd4) ? r_r + 3'd1 : r_r;
          end
        end
        S_ISSUE: begin
          if (!cop_wait) begin
            cop_activate <= 1'b0;
            r_armed      <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // a done seen before the coprocessor has raised wait belongs to an earlier job
          if (cop_wait) r_armed <= 1'b1;
          if (r_armed && cop_done) begin
            dst_wdata <= w_sat;
            dst_addr  <= r_y * ADDR_W'(IMG_W) + r_x;
            dst_we    <= 1'b1;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          dst_we <= 1'b0;
          r_k    <= '0;
          r_r    <= '0;
          r_c    <= '0;
          if (w_last) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_x     <= (r_x == ADDR_W'(IMG_W-1)) ? '0 : r_x + 1'b1;
            r_y     <= (r_x == ADDR_W'(IMG_W-1)) ? r_y + 1'b1 : r_y;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipu_window_sequencer.sv
// tb_ipu_window_sequencer: randomized scoreboard bench with a behavioural frame/convolution reference
module tb_ipu_window_sequencer;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int AW = 15;
  typedef struct {int addr; int data;} exp_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'b01;
  logic [199:0] kernel_b = '0;
  logic busy, done, dst_we, ipu_request, cop_activate;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0] src_rdata = 8'd0, dst_wdata;
  logic [199:0] window_a, window_b;
  logic [31:0] cop_instruction, cop_result;
  logic cop_wait, cop_done;
  int checks = 0, errors = 0, writes = 0, dones = 0, cyc;
  int img[N];
  int kern[25];
  int obs[N];
  logic [7:0] src_mem[N];
  exp_t q[$];
  int stall_n = 0;
  bit stale = 1'b0, ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  ipu_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .kernel_b(kernel_b),
    .busy(busy), .done(done), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_we(dst_we),
    .ipu_request(ipu_request), .window_a(window_a), .window_b(window_b),
    .cop_instruction(cop_instruction), .cop_activate(cop_activate),
    .cop_wait(cop_wait), .cop_done(cop_done), .cop_result(cop_result));

  always #5 clk = ~clk;
  always @(posedge clk) src_rdata <= (int'(src_addr) < N) ? src_mem[src_addr] : 8'hEE;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  function automatic int sat(input int v);
    logic [23:0] b;
    b = v[23:0];
    return b[23] ? 0 : (b > 24'd255 ? 255 : int'(b));
  endfunction

  function automatic int ref_pix(input int x, input int y);
    int s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        int yy = y + r - 2, xx = x + c - 2;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W) s += img[yy*W+xx] * kern[r*5+c];
      end
    return sat(s);
  endfunction

  task automatic load(input int pix_max, input int k_max, input bit konst);
    for (int i = 0; i < N; i++) begin
      img[i] = konst ? 10 : int'($urandom_range(pix_max, 0));
      src_mem[i] = 8'(img[i]);
    end
    for (int k = 0; k < 25; k++) begin
      kern[k] = konst ? 1 : int'($urandom_range(k_max, 0));
      kernel_b[8*k +: 8] = 8'(kern[k]);
    end
  endtask

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        q.push_back('{y*W+x, ovr_en ? sat(int'(ovr_val[23:0])) : ref_pix(x, y)});
  endtask

  task automatic run_frame(input logic [1:0] m, input bit poke);
    logic [31:0] ei;
    ei = {28'd0, 2'b01, (m == 2'b00) ? 2'b01 : m};
    push_frame();
    writes = 0;
    dones = 0;
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("instr", {32'd0, cop_instruction}, {32'd0, ei});
    if (poke) begin
      repeat (200) @(negedge clk);
      mode = 2'b10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("instr_held", {32'd0, cop_instruction}, {32'd0, ei});
    end
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("frame_timeout", {63'd0, done}, 64'd1);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("writes", 64'(writes), 64'(N));
    @(negedge clk);
    chk("done_pulse_len", {63'd0, done}, 64'd0);
    chk("done_count", 64'(dones), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) if (reset_n) begin
    if (dst_we) begin
      writes++;
      if (int'(dst_addr) < N) obs[dst_addr] = int'(dst_wdata);
      if (q.size() == 0) chk("unexpected_write", 64'(dst_addr), 64'hFFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(dst_addr), 64'(e.addr));
        chk("wr_data", 64'(dst_wdata), 64'(e.data));
      end
    end
    if (done) dones++;
  end

  initial begin
    int sum;
    logic [31:0] res;
    cop_wait = 1'b0;
    cop_done = 1'b0;
    cop_result = '0;
    forever begin
      @(negedge clk);
      if (reset_n && cop_activate) begin
        if (stall_n > 0) begin
          cop_wait = 1'b1;
          repeat (stall_n) begin
            @(negedge clk);
            chk("stall_activate", {63'd0, cop_activate}, 64'd1);
          end
          stall_n = 0;
          cop_wait = 1'b0;
        end
        sum = 0;
        for (int k = 0; k < 25; k++) sum += int'(window_a[8*k +: 8]) * int'(window_b[8*k +: 8]);
        res = ovr_en ? ovr_val : {8'hA5, sum[23:0]};
        @(negedge clk);
        chk("accept_first_free", {63'd0, cop_activate}, 64'd0);
        chk("ipu_request", {63'd0, ipu_request}, 64'd1);
        if (stale) begin
          cop_done = 1'b1;
          @(negedge clk);
          cop_done = 1'b0;
          stale = 1'b0;
          chk("stale_no_write", {63'd0, dst_we}, 64'd0);
        end
        cop_wait = 1'b1;
        repeat (3) @(negedge clk);
        cop_wait = 1'b0;
        cop_done = 1'b1;
        cop_result = res;
        @(negedge clk);
        cop_done = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_outs", {59'd0, done, dst_we, ipu_request, cop_activate, |window_a}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    load(0, 0, 1'b1);
    run_frame(2'b01, 1'b0);
    chk("interior_3_2", 64'(obs[2*W+3]), 64'd250);
    chk("corner_0_0", 64'(obs[0]), 64'd90);
    chk("edge_3_0", 64'(obs[3]), 64'd150);
    load(20, 1, 1'b0);
    stall_n = 10;
    stale = 1'b1;
    run_frame(2'b10, 1'b0);
    load(20, 1, 1'b0);
    run_frame(2'b00, 1'b1);
    load(30, 1, 1'b0);
    run_frame(2'b11, 1'b0);
    ovr_en = 1'b1;
    ovr_val = 32'hAB00012C;
    run_frame(2'b01, 1'b0);
    chk("sat_hi", 64'(obs[5]), 64'd255);
    ovr_val = 32'h00FFFFFB;
    run_frame(2'b01, 1'b0);
    chk("sat_neg", 64'(obs[5]), 64'd0);
    ovr_en = 1'b0;
    load(0, 0, 1'b1);
    push_frame();
    writes = 0;
    @(negedge clk);
    mode = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (writes < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("third_write_seen", 64'(writes), 64'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_window_a", {63'd0, |window_a}, 64'd0);
    chk("mid_rst_window_b", {63'd0, |window_b}, 64'd0);
    chk("mid_rst_instr", {32'd0, cop_instruction}, 64'd0);
    chk("mid_rst_addr", {34'd0, src_addr, dst_addr}, 64'd0);
    chk("mid_rst_ctl", {52'd0, dst_wdata, done, dst_we, ipu_request, cop_activate}, 64'd0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(2'b01, 1'b0);
    chk("restart_corner", 64'(obs[0]), 64'd90);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
